button_command_encoder: RTL and testbench

BUTTON_COMMAND_ENCODER -- requirements
Module: button_command_encoder

---
 rtl/button_command_encoder_pkg.sv | 26 ++
 rtl/button_command_encoder_debouncer.sv | 54 +++++
 rtl/button_command_encoder.sv | 97 +++++++++
 tb/tb_button_command_encoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/button_command_encoder_pkg.sv
// Shared direction codes and command-state encoding for the button command encoder.
`default_nettype none

package button_command_encoder_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned NUM_BUTTONS = 4;

  // Button vector bit positions.
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } cmd_state_t;

endpackage : button_command_encoder_pkg

`default_nettype wire

// File: rtl/button_command_encoder_debouncer.sv
// button_debouncer: one push-button synchronizer, debounce counter, stable level and press pulse.
`default_nettype none

module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= button_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  // Rising edge of the debounced level only; releases are silent.
  assign press_o = stable_q & ~prev_q;

endmodule : button_debouncer

`default_nettype wire

// File: rtl/button_command_encoder.sv
// Debounces four direction buttons and holds the latest press as a pending command until acked.
`default_nettype none

module button_command_encoder
  import button_command_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic       cmd_ack,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic [1:0] cur_dir
);

  logic [NUM_BUTTONS-1:0] press;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debouncer (
      .clk     (clk),
      .reset   (reset),
      .button_i(button[i]),
      .press_o (press[i])
    );
  end

  logic       any_press;
  logic [1:0] winner;

  always_comb begin
    winner = DIR_RIGHT;
    if (press[BTN_UP]) begin
      winner = DIR_UP;
    end else if (press[BTN_DOWN]) begin
      winner = DIR_DOWN;
    end else if (press[BTN_LEFT]) begin
      winner = DIR_LEFT;
    end
  end

  assign any_press = |press;

  cmd_state_t state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] cur_dir_q, cur_dir_d;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cur_dir_d = cur_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          state_d = ST_PENDING;
          dir_d   = winner;
        end
      end
      ST_PENDING: begin
        if (cmd_ack) begin
          cur_dir_d = dir_q;
        end
        // A fresh press keeps the command pending even when the old one is consumed.
        if (any_press) begin
          dir_d = winner;
        end else if (cmd_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      cur_dir_q <= DIR_RIGHT;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cur_dir_q <= cur_dir_d;
    end
  end

  assign dir       = dir_q;
  assign dir_valid = (state_q == ST_PENDING);
  assign cur_dir   = cur_dir_q;

endmodule : button_command_encoder

`default_nettype wire

// File: tb/tb_button_command_encoder.sv
// Directed self-checking bench for button_command_encoder with DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_button_command_encoder;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button = 4'b0000;
  logic       cmd_ack = 1'b0;
  logic [1:0] dir;
  logic       dir_valid;
  logic [1:0] cur_dir;

  int n_checks = 0;
  int n_errors = 0;

  button_command_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .cmd_ack  (cmd_ack),
    .dir      (dir),
    .dir_valid(dir_valid),
    .cur_dir  (cur_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [1:0] e_dir, input logic e_val,
                      input logic [1:0] e_cur);
    check({tag, ".dir"}, dir, e_dir);
    check({tag, ".valid"}, {1'b0, dir_valid}, {1'b0, e_val});
    check({tag, ".cur"}, cur_dir, e_cur);
  endtask

  initial begin
    logic seen_valid;

    tick(2);
    outs("reset", 2'b00, 1'b0, 2'b11);
    reset = 1'b0;
    tick(2);

    // Latency: down held from edge 0, valid only after edge DEB+2.
    button = 4'b0100;
    for (int e = 0; e <= DEB + 1; e++) begin
      tick(1);
      check($sformatf("lat.e%0d", e), {1'b0, dir_valid}, 2'b00);
    end
    tick(1);
    outs("lat.e6", 2'b01, 1'b1, 2'b11);
    button = 4'b0000;
    tick(10);
    ack_pulse();
    outs("ack_down", 2'b01, 1'b0, 2'b01);

    // Short glitch on left is rejected, long hold produces one command.
    seen_valid = 1'b0;
    button = 4'b0010;
    tick(3);
    button = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen_valid |= dir_valid;
    end
    check("glitch", {1'b0, seen_valid}, 2'b00);
    button = 4'b0010;
    tick(10);
    outs("left_hold", 2'b10, 1'b1, 2'b01);
    button = 4'b0000;
    tick(10);
    ack_pulse();
    outs("left_ack", 2'b10, 1'b0, 2'b10);
    tick(3);
    check("left_once", {1'b0, dir_valid}, 2'b00);

    // Up and right together: up wins.
    button = 4'b1001;
    tick(DEB + 3);
    outs("prio", 2'b00, 1'b1, 2'b10);
    tick(4);
    check("prio_hold", dir, 2'b00);
    ack_pulse();
    outs("prio_ack", 2'b00, 1'b0, 2'b00);
    button = 4'b0000;
    tick(10);

    // Pending down, then right press event coincides with cmd_ack.
    button = 4'b0100;
    tick(DEB + 3);
    outs("pend_down", 2'b01, 1'b1, 2'b00);
    button = 4'b0000;
    tick(10);
    check("release_noevt", dir, 2'b01);
    button = 4'b0001;
    tick(DEB + 2);
    outs("pre_same", 2'b01, 1'b1, 2'b00);
    ack_pulse();
    outs("same_cycle", 2'b11, 1'b1, 2'b01);
    button = 4'b0000;
    tick(10);
    ack_pulse();
    outs("right_ack", 2'b11, 1'b0, 2'b11);

    // cmd_ack while idle changes nothing.
    ack_pulse();
    outs("idle_ack", 2'b11, 1'b0, 2'b11);

    // Reset mid-debounce: no stale event afterwards.
    button = 4'b1000;
    tick(3);
    reset = 1'b1;
    #2;
    outs("rst_mid", 2'b00, 1'b0, 2'b11);
    button = 4'b0000;
    tick(2);
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      seen_valid |= dir_valid;
    end
    check("rst_mid_stale", {1'b0, seen_valid}, 2'b00);

    // Reset while pending, button held through release.
    button = 4'b0010;
    tick(DEB + 3);
    button = 4'b0000;
    tick(10);
    ack_pulse();
    outs("pre_rst_left", 2'b10, 1'b0, 2'b10);
    button = 4'b0100;
    tick(DEB + 3);
    outs("pre_rst_pend", 2'b01, 1'b1, 2'b10);
    reset = 1'b1;
    #2;
    outs("rst_pend", 2'b00, 1'b0, 2'b11);
    tick(2);
    reset = 1'b0;
    for (int e = 0; e <= DEB + 1; e++) begin
      tick(1);
      check($sformatf("rst_lat.e%0d", e), {1'b0, dir_valid}, 2'b00);
    end
    tick(1);
    outs("rst_lat.e6", 2'b01, 1'b1, 2'b11);
    tick(10);
    check("rst_once", dir, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_button_command_encoder

`default_nettype wire
